// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-lite decode stage.
//   opcode_e  : 6-bit primary opcode encoding (0x00..0x11 defined).
//   ctrl_t    : control bundle carried in the ID/EX register.
//   ALU_*     : alu_op encodings.
//   *_LSB     : instruction field positions (each register field is 5 bits wide).
//   state_e   : decode-stage run/halt state.
// Control choices for fields not tied to a register write: wb_alu is 1 only for
// ALU results written back; src2_reg is 1 when the second ALU operand is rt
// (R-type ALU ops and beq).
package mips_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
    OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_BZ  = 3'b110;
  localparam logic [2:0] ALU_BEQ = 3'b111;

  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  typedef struct packed {
    logic       reg_we;
    logic       mem_we;
    logic       wb_alu;
    logic       src2_reg;
    logic       is_load;
    logic       is_bz;
    logic       is_beq;
    logic       is_jr;
    logic       is_halt;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file, 2 read ports, 1 write port.
//   ra_addr/ra_data, rb_addr/rb_data : combinational reads
//   we, wa_addr, wa_data             : write, lands on posedge clk
// r0 always reads 0 and is never written. A read of the register being written
// in the same cycle returns the incoming data (write-through).
module regfile_bypass #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  localparam int RI_W   = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RI_W-1:0]   ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [RI_W-1:0]   rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [RI_W-1:0]   wa_addr,
  input  logic [DATA_W-1:0] wa_data
);

  logic [DATA_W-1:0] regs [REG_NUM];
  logic              wr_en;

  assign wr_en = we && (wa_addr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa_addr] <= wa_data;
    end
  end

  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == '0)                      ra_data = '0;
    else if (wr_en && (wa_addr == ra_addr)) ra_data = wa_data;
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (rb_addr == '0)                      rb_data = '0;
    else if (wr_en && (wa_addr == rb_addr)) rb_data = wa_data;
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage: register file, instruction decode, load-use stall, ID/EX
// register, halt state machine and instruction-class counters.
//   if_valid/if_instr/id_ready : IF/ID handshake (accept = if_valid & id_ready)
//   ex_flush                   : current IF/ID instruction is wrong-path
//   wb_we/wb_rd/wb_data        : register write from WB
//   idex_*                     : ID/EX register outputs
//   halted, illegal_op         : status; cnt_*: saturating class counters
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_RUN     | normal decode
// ST_HALTED  | halt issued; no more instructions accepted until reset
module id_stage_pipelined
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int IMM_W   = 16,
  parameter int CNT_W   = 32,
  localparam int RI_W   = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  output logic              id_ready,
  input  logic              ex_flush,
  input  logic              wb_we,
  input  logic [RI_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              idex_valid,
  output ctrl_t             idex_ctrl,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [RI_W-1:0]   idex_rs,
  output logic [RI_W-1:0]   idex_rt,
  output logic [RI_W-1:0]   idex_rd,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  cnt_total,
  output logic [CNT_W-1:0]  cnt_arith,
  output logic [CNT_W-1:0]  cnt_logic,
  output logic [CNT_W-1:0]  cnt_mem,
  output logic [CNT_W-1:0]  cnt_branch
);

  logic [OPC_W-1:0]  op_raw;
  opcode_e           opcode;
  logic [RI_W-1:0]   rs, rt, rd;
  logic [DATA_W-1:0] imm_sext, rf_rs_data, rf_rt_data;
  ctrl_t             dec_ctrl;
  logic              dec_legal, dec_rtype, rs_used, rt_used, imm_en;
  logic [RI_W-1:0]   dec_rd;
  logic              hazard, take;
  state_e            state, state_nxt;

  assign op_raw   = if_instr[OPC_LSB +: OPC_W];
  assign opcode   = opcode_e'(op_raw);
  assign rs       = if_instr[RS_LSB +: RI_W];
  assign rt       = if_instr[RT_LSB +: RI_W];
  assign rd       = if_instr[RD_LSB +: RI_W];
  assign imm_sext = {{(DATA_W-IMM_W){if_instr[IMM_W-1]}}, if_instr[IMM_W-1:0]};

  regfile_bypass #(.DATA_W(DATA_W), .REG_NUM(REG_NUM)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ra_addr (rs),
    .ra_data (rf_rs_data),
    .rb_addr (rt),
    .rb_data (rf_rt_data),
    .we      (wb_we),
    .wa_addr (wb_rd),
    .wa_data (wb_data)
  );

  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    dec_rtype = 1'b0;
    rs_used   = 1'b1;
    rt_used   = 1'b0;
    imm_en    = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        dec_rtype         = 1'b1;
        rt_used           = 1'b1;
        imm_en            = 1'b0;
        dec_ctrl.reg_we   = 1'b1;
        dec_ctrl.wb_alu   = 1'b1;
        dec_ctrl.src2_reg = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        dec_ctrl.reg_we = 1'b1;
        dec_ctrl.wb_alu = 1'b1;
      end
      OP_LDW: begin
        dec_ctrl.reg_we  = 1'b1;
        dec_ctrl.is_load = 1'b1;
      end
      OP_STW: begin
        rt_used         = 1'b1;
        dec_ctrl.mem_we = 1'b1;
      end
      OP_BZ:  dec_ctrl.is_bz = 1'b1;
      OP_BEQ: begin
        rt_used           = 1'b1;
        dec_ctrl.is_beq   = 1'b1;
        dec_ctrl.src2_reg = 1'b1;
      end
      OP_JR:  dec_ctrl.is_jr = 1'b1;
      OP_HALT: begin
        rs_used          = 1'b0;
        imm_en           = 1'b0;
        dec_ctrl.is_halt = 1'b1;
      end
      default: begin
        // undefined opcodes read nothing and decode to a bubble
        dec_legal = 1'b0;
        rs_used   = 1'b0;
        imm_en    = 1'b0;
      end
    endcase

    case (opcode)
      OP_SUB, OP_SUBI: dec_ctrl.alu_op = ALU_SUB;
      OP_MUL, OP_MULI: dec_ctrl.alu_op = ALU_MUL;
      OP_OR,  OP_ORI:  dec_ctrl.alu_op = ALU_OR;
      OP_AND, OP_ANDI: dec_ctrl.alu_op = ALU_AND;
      OP_XOR, OP_XORI: dec_ctrl.alu_op = ALU_XOR;
      OP_BZ:           dec_ctrl.alu_op = ALU_BZ;
      OP_BEQ:          dec_ctrl.alu_op = ALU_BEQ;
      default:         dec_ctrl.alu_op = ALU_ADD;
    endcase

    dec_rd = '0;
    if (dec_ctrl.reg_we) dec_rd = dec_rtype ? rd : rt;
  end

  // Loaded value is not available until after EX/MEM, so a consumer directly
  // behind a load must wait one cycle.
  always_comb begin
    hazard = idex_valid && idex_ctrl.is_load && (idex_rd != '0) &&
             ((rs_used && (rs == idex_rd)) || (rt_used && (rt == idex_rd)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    id_ready  = 1'b0;
    take      = 1'b0;
    case (state)
      ST_RUN: begin
        // flush drains the wrong-path instruction even if it would stall
        id_ready = ex_flush || !hazard;
        take     = if_valid && id_ready && !ex_flush;
        if (take && (opcode == OP_HALT)) state_nxt = ST_HALTED;
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  assign halted = (state == ST_HALTED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_valid   <= 1'b0;
      idex_ctrl    <= '0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
    end else if (take && dec_legal) begin
      idex_valid   <= 1'b1;
      idex_ctrl    <= dec_ctrl;
      idex_rs_data <= rf_rs_data;
      idex_rt_data <= rf_rt_data;
      idex_imm     <= imm_en ? imm_sext : '0;
      idex_rs      <= rs;
      idex_rt      <= rt;
      idex_rd      <= dec_rd;
    end else begin
      idex_valid   <= 1'b0;
      idex_ctrl    <= '0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_total  <= '0;
      cnt_arith  <= '0;
      cnt_logic  <= '0;
      cnt_mem    <= '0;
      cnt_branch <= '0;
      illegal_op <= 1'b0;
    end else if (take) begin
      cnt_total <= sat_inc(cnt_total);
      if (!dec_legal) illegal_op <= 1'b1;
      if (op_raw inside {[6'h00:6'h05]}) cnt_arith  <= sat_inc(cnt_arith);
      if (op_raw inside {[6'h06:6'h0B]}) cnt_logic  <= sat_inc(cnt_logic);
      if (op_raw inside {[6'h0C:6'h0D]}) cnt_mem    <= sat_inc(cnt_mem);
      if (op_raw inside {[6'h0E:6'h11]}) cnt_branch <= sat_inc(cnt_branch);
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
module tb_id_stage_pipelined;
  import mips_pkg::*;

  localparam int DATA_W  = 32;
  localparam int REG_NUM = 32;
  localparam int IMM_W   = 16;
  localparam int CNT_W   = 4;   // small so saturation is reached in the random phase
  localparam int RI_W    = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              if_valid = 1'b0;
  logic [31:0]       if_instr = '0;
  logic              id_ready;
  logic              ex_flush = 1'b0;
  logic              wb_we = 1'b0;
  logic [RI_W-1:0]   wb_rd = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              idex_valid;
  ctrl_t             idex_ctrl;
  logic [DATA_W-1:0] idex_rs_data, idex_rt_data, idex_imm;
  logic [RI_W-1:0]   idex_rs, idex_rt, idex_rd;
  logic              halted, illegal_op;
  logic [CNT_W-1:0]  cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_branch;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr),
    .id_ready(id_ready), .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .idex_valid(idex_valid), .idex_ctrl(idex_ctrl),
    .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd), .halted(halted),
    .illegal_op(illegal_op), .cnt_total(cnt_total), .cnt_arith(cnt_arith),
    .cnt_logic(cnt_logic), .cnt_mem(cnt_mem), .cnt_branch(cnt_branch)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]      m_regs [32];
  logic             m_vld, m_halted, m_ill;
  logic [11:0]      m_ctrl;
  logic [31:0]      m_rsd, m_rtd, m_imm;
  logic [4:0]       m_rs, m_rt, m_rd;
  logic [CNT_W-1:0] m_cnt [5];   // total, arith, logic, mem, branch

  function automatic bit legal(input logic [5:0] op);    return op <= 6'h11; endfunction
  function automatic bit is_rtype(input logic [5:0] op); return (op <= 6'h0A) && !op[0]; endfunction
  function automatic bit uses_rs(input logic [5:0] op);  return op <= 6'h10; endfunction
  function automatic bit uses_rt(input logic [5:0] op);
    return is_rtype(op) || op == 6'h0D || op == 6'h0F;
  endfunction

  function automatic logic [11:0] ctrl_of(input logic [5:0] op);
    logic [2:0] alu;
    if (op <= 6'h0B)      alu = 3'(op >> 1);
    else if (op == 6'h0E) alu = 3'd6;
    else if (op == 6'h0F) alu = 3'd7;
    else                  alu = 3'd0;
    return {op <= 6'h0C, op == 6'h0D, op <= 6'h0B, is_rtype(op) || op == 6'h0F,
            op == 6'h0C, op == 6'h0E, op == 6'h0F, op == 6'h10, op == 6'h11, alu};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_ready();
    logic [5:0] op;
    bit hz;
    op = if_instr[31:26];
    hz = m_vld && m_ctrl[7] && m_rd != 0 && legal(op) &&
         ((uses_rs(op) && if_instr[25:21] == m_rd) || (uses_rt(op) && if_instr[20:16] == m_rd));
    if (m_halted) return 0;
    if (ex_flush) return 1;
    return !hz;
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [5:0] op;
    bit take;
    int cls;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      m_vld = 0; m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_halted = 0; m_ill = 0;
    end else begin
      op   = if_instr[31:26];
      take = if_valid && m_ready() && !ex_flush;
      if (take && legal(op)) begin
        m_vld  = 1;
        m_ctrl = ctrl_of(op);
        m_rs   = if_instr[25:21];
        m_rt   = if_instr[20:16];
        m_rsd  = m_read(m_rs);
        m_rtd  = m_read(m_rt);
        m_rd   = (op <= 6'h0C) ? (is_rtype(op) ? if_instr[15:11] : if_instr[20:16]) : 5'd0;
        m_imm  = (is_rtype(op) || op == 6'h11) ? 32'd0 : {{16{if_instr[15]}}, if_instr[15:0]};
      end else begin
        m_vld = 0; m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0;
      end
      if (take) begin
        m_cnt[0] = sat(m_cnt[0]);
        if (legal(op)) begin
          cls = (op <= 5) ? 1 : (op <= 11) ? 2 : (op <= 13) ? 3 : 4;
          m_cnt[cls] = sat(m_cnt[cls]);
        end else m_ill = 1;
        if (op == 6'h11) m_halted = 1;
      end
      if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("id_ready", id_ready, m_ready());
      chk("idex_valid", idex_valid, m_vld);
      chk("idex_ctrl", idex_ctrl, m_ctrl);
      chk("idex_rs_data", idex_rs_data, m_rsd);
      chk("idex_rt_data", idex_rt_data, m_rtd);
      chk("idex_imm", idex_imm, m_imm);
      chk("idex_rs", idex_rs, m_rs);
      chk("idex_rt", idex_rt, m_rt);
      chk("idex_rd", idex_rd, m_rd);
      chk("halted", halted, m_halted);
      chk("illegal_op", illegal_op, m_ill);
      chk("cnt_total", cnt_total, m_cnt[0]);
      chk("cnt_arith", cnt_arith, m_cnt[1]);
      chk("cnt_logic", cnt_logic, m_cnt[2]);
      chk("cnt_mem", cnt_mem, m_cnt[3]);
      chk("cnt_branch", cnt_branch, m_cnt[4]);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {op, s, t, d, 11'd0};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    if_valid = v; if_instr = ins; ex_flush = fl; wb_we = we; wb_rd = wr; wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    op = ($urandom_range(0, 3) == 0) ? 6'h0C : 6'($urandom_range(0, 16));
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  initial begin
    logic [31:0] cur;
    bit acc;

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst idex_valid", idex_valid, 0);
    chk("rst idex_ctrl", idex_ctrl, 0);
    chk("rst halted", halted, 0);
    chk("rst cnt_total", cnt_total, 0);
    reset_n = 1;

    drive(0, 0, 0, 1, 3, 32'h5); tick();
    drive(1, enc_r(6'h00, 3, 3, 1), 0, 0, 0, 0); tick();
    chk("add rs_data", idex_rs_data, 5);
    chk("add rt_data", idex_rt_data, 5);
    chk("add rd", idex_rd, 1);
    chk("add alu_op", idex_ctrl.alu_op, 0);
    chk("add cnt_arith", cnt_arith, 1);

    drive(1, enc_i(6'h01, 0, 2, 16'hFFFC), 0, 0, 0, 0); tick();
    chk("addi imm", idex_imm, 32'hFFFF_FFFC);
    chk("addi src2_reg", idex_ctrl.src2_reg, 0);
    chk("addi rd", idex_rd, 2);

    drive(1, enc_i(6'h0C, 1, 4, 0), 0, 0, 0, 0); tick();
    chk("ldw is_load", idex_ctrl.is_load, 1);
    drive(1, enc_r(6'h00, 4, 1, 5), 0, 0, 0, 0); #1;
    chk("stall id_ready", id_ready, 0);
    tick();
    chk("stall bubble", idex_valid, 0);
    chk("stall release", id_ready, 1);
    tick();
    chk("post-stall valid", idex_valid, 1);
    chk("post-stall rd", idex_rd, 5);

    drive(1, enc_i(6'h0C, 1, 0, 0), 0, 0, 0, 0); tick();
    drive(1, enc_r(6'h00, 4, 1, 5), 0, 0, 0, 0); #1;
    chk("ldw r0 no stall", id_ready, 1);
    tick();
    chk("ldw r0 add valid", idex_valid, 1);

    drive(1, enc_r(6'h06, 7, 0, 8), 0, 1, 7, 32'hA5); tick();
    chk("bypass rs_data", idex_rs_data, 32'hA5);
    chk("bypass rd", idex_rd, 8);

    drive(1, enc_i(6'h0F, 1, 2, 16'd4), 0, 0, 0, 0); tick();
    chk("beq is_beq", idex_ctrl.is_beq, 1);
    drive(1, enc_r(6'h00, 1, 1, 9), 1, 0, 0, 0); #1;
    chk("flush id_ready", id_ready, 1);
    tick();
    chk("flush bubble", idex_valid, 0);
    chk("flush cnt_total", cnt_total, 8);

    drive(1, {6'h3F, 26'd0}, 0, 0, 0, 0); tick();
    chk("illegal sticky", illegal_op, 1);
    chk("illegal bubble", idex_valid, 0);
    chk("illegal cnt_total", cnt_total, 9);
    chk("illegal cnt_arith", cnt_arith, 4);

    drive(1, {6'h11, 26'd0}, 0, 0, 0, 0); tick();
    chk("halt halted", halted, 1);
    chk("halt is_halt", idex_ctrl.is_halt, 1);
    chk("halt cnt_branch", cnt_branch, 2);
    drive(1, enc_r(6'h00, 1, 1, 1), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("halted id_ready", id_ready, 0);
      tick();
    end

    reset_n = 0; #1;
    chk("reset halted", halted, 0);
    chk("reset illegal_op", illegal_op, 0);
    chk("reset cnt_total", cnt_total, 0);
    chk("reset idex_valid", idex_valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1;
    drive(1, enc_r(6'h00, 3, 3, 1), 0, 0, 0, 0); tick();
    chk("reset clears r3", idex_rs_data, 0);

    cur = rand_instr();
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 9) != 0, cur, $urandom_range(0, 11) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      #1;
      acc = if_valid && id_ready;
      tick();
      if (acc) cur = rand_instr();
    end
    chk("counters saturated", cnt_total, 4'hF);

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
